e203_ifu_bpu_prdt: RTL and testbench
====================================

Name: e203_ifu_bpu_prdt

Overview:
- Consumer side of the IFU mini-decode info bus: takes decoded branch/jump fields for the fetched instruction and produces the predicted next-fetch PC.
- Sits in the IFU beside the mini-decoder, feeding the PC-generation mux.
- Resolves JALR targets from x0, x1 or a general register xN.
- Runs a small FSM that stalls fetch for register dependencies and for a one-cycle regfile read of xN.

Parameters:
- PC_W, 32, PC width.
- XLEN, 32, register and immediate width.
- RFIDX_W, 5, register index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- dec_vld  in  1  decoded-info bus valid for the current IR instruction.
- dec_jal  in  1  instruction is JAL.
- dec_jalr  in  1  instruction is JALR.
- dec_bxx  in  1  instruction is a conditional branch.
- dec_bjp_imm  in  XLEN  sign-extended branch/jump offset.
- dec_jalr_rs1idx  in  RFIDX_W  JALR rs1 index.
- pc  in  PC_W  PC of the decoded instruction.
- oitf_empty  in  1  no outstanding long-pipe writebacks.
- ir_valid  in  1  an older instruction occupies the EXU IR.
- ir_rdwen  in  1  that instruction writes rd.
- ir_rdidx  in  RFIDX_W  that instruction's rd.
- rf2bpu_x1  in  XLEN  direct x1 value.
- rf2bpu_rs1  in  XLEN  shared regfile read-port data; valid the cycle after bpu2rf_rs1_ena.
- bpu2rf_rs1_ena  out  1  one-cycle read request on the shared rs1 port.
- bpu_wait  out  1  stall fetch; target not yet available.
- prdt_vld  out  1  prediction result valid this cycle.
- prdt_taken  out  1  predicted taken.
- prdt_tgt  out  PC_W  predicted target (pc+4 or pc+2 handled outside when not taken).

Behaviour:
- Reset values: all outputs 0; state IDLE; held rs1 register 0.
- Class decode, only when dec_vld=1:
  - JAL: taken; target = pc + imm; prdt_vld same cycle, no wait.
  - BXX: taken iff the optional feature rule says so; target = pc + imm; same cycle.
  - JALR, rs1=x0: target = imm; same cycle.
  - JALR, rs1=x1: depends on x1 (oitf_empty=0, or ir_valid & ir_rdwen & ir_rdidx==1).
    - Dependent: bpu_wait=1, go DEP_WAIT.
    - Otherwise: target = rf2bpu_x1 + imm, same cycle.
  - JALR, rs1=xN (N>1): always at least one extra cycle.
    - Dependent on xN (same rule with rdidx==N): go DEP_WAIT.
    - Otherwise: assert bpu2rf_rs1_ena, bpu_wait=1, go RD_XN.
  - Non-jump instruction: prdt_vld=1, prdt_taken=0.
- FSM states:
  - IDLE: see the class decode rules above.
  - DEP_WAIT: bpu_wait=1.
    - When the dependency clears: x1 case goes to IDLE and produces the result the same cycle; xN case issues bpu2rf_rs1_ena and goes to RD_XN.
  - RD_XN: bpu_wait=0, prdt_vld=1, prdt_taken=1, target = rf2bpu_rs1 + imm; return to IDLE.
- Read-request rule: bpu2rf_rs1_ena pulses for exactly one cycle per xN JALR; it never pulses in two consecutive cycles.
- Arithmetic: the sum is computed at XLEN width and truncated to PC_W; wrap-around is modulo 2^PC_W with no overflow flag. Bit 0 of the JALR target is forced to 0.
- Input holding: dec_* fields and pc are held stable by the IFU while bpu_wait=1.
- If dec_vld drops in DEP_WAIT or RD_XN (flush): abort to IDLE next cycle with no prdt_vld.
- If rst_n=0 mid-operation: state returns to IDLE on the next edge and any outstanding read result is discarded.
- Simultaneous cases:
  - Dependency cleared and flush in the same cycle: flush wins.
  - x1 dependency with rs1idx==1: uses the x1 path, never the read port.

Optional Feature:
- Macro: E203_BPU_BACKWARD_TAKEN_EN.
- Defined: BXX is predicted taken iff dec_bjp_imm[XLEN-1]=1 (backward offset).
- Undefined: BXX is always predicted not-taken and prdt_tgt = pc + imm is still driven.

Decomposition:
- Package e203_bpu_pkg holds:
  - enum bpu_state_e {IDLE, DEP_WAIT, RD_XN};
  - enum jalr_src_e {SRC_X0, SRC_X1, SRC_XN};
  - constant RFIDX_X1 = 1.
- One sub-module, e203_ifu_bpu_depchk: combinational dependency check taking (rs1idx, oitf_empty, ir_valid, ir_rdwen, ir_rdidx) and producing dep.

Test Plan:
- JAL, pc=0x1000, imm=0x20 -> same cycle: prdt_vld=1, taken=1, tgt=0x1020, bpu_wait=0.
- BXX, pc=0x2000, imm=0xFFFFFFF0:
  - macro defined -> taken=1, tgt=0x1FF0;
  - macro undefined -> taken=0.
- JALR x1, x1=0x3001, imm=4, ir_rdidx=1 with ir_rdwen=1 for 2 cycles:
  - bpu_wait=1 for 2 cycles;
  - then tgt=0x3004 with bit0 cleared.
- JALR x5, no dependency, rf2bpu_rs1=0x4000, imm=8:
  - cycle0: ena=1, wait=1;
  - cycle1: prdt_vld=1, tgt=0x4008.
- JALR x7, oitf_empty=0, then dec_vld dropped -> IDLE next cycle; no ena pulse, no prdt_vld.
- pc=0xFFFFFFF8, JAL imm=0x10 -> tgt=0x00000008 (wrap).
- rst_n low mid-RD_XN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/e203_bpu_pkg.sv
// rtl/e203_bpu_pkg.sv - shared types and constants for the IFU branch predictor
package e203_bpu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEP_WAIT = 2'd1,
        RD_XN    = 2'd2
    } bpu_state_e;

    typedef enum logic [1:0] {
        SRC_X0 = 2'd0,
        SRC_X1 = 2'd1,
        SRC_XN = 2'd2
    } jalr_src_e;

    localparam int RFIDX_X1 = 1;

endpackage

// File: rtl/e203_ifu_bpu_depchk.sv
// rtl/e203_ifu_bpu_depchk.sv - JALR rs1 read-after-write hazard check
module e203_ifu_bpu_depchk #(
    parameter int RFIDX_W = 5
) (
    input  logic [RFIDX_W-1:0] rs1idx,
    input  logic               oitf_empty,
    input  logic               ir_valid,
    input  logic               ir_rdwen,
    input  logic [RFIDX_W-1:0] ir_rdidx,
    output logic               dep
);

    // Any outstanding long-pipe write may target rs1, so it is treated as a hazard
    // alongside an exact rd match in the EXU IR.
    always_comb begin
        dep = ~oitf_empty | (ir_valid & ir_rdwen & (ir_rdidx == rs1idx));
    end

endmodule

// File: rtl/e203_ifu_bpu_prdt.sv
// rtl/e203_ifu_bpu_prdt.sv - next-fetch PC prediction (optional E203_BPU_BACKWARD_TAKEN_EN)
module e203_ifu_bpu_prdt
    import e203_bpu_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dec_vld,
    input  logic               dec_jal,
    input  logic               dec_jalr,
    input  logic               dec_bxx,
    input  logic [XLEN-1:0]    dec_bjp_imm,
    input  logic [RFIDX_W-1:0] dec_jalr_rs1idx,
    input  logic [PC_W-1:0]    pc,
    input  logic               oitf_empty,
    input  logic               ir_valid,
    input  logic               ir_rdwen,
    input  logic [RFIDX_W-1:0] ir_rdidx,
    input  logic [XLEN-1:0]    rf2bpu_x1,
    input  logic [XLEN-1:0]    rf2bpu_rs1,
    output logic               bpu2rf_rs1_ena,
    output logic               bpu_wait,
    output logic               prdt_vld,
    output logic               prdt_taken,
    output logic [PC_W-1:0]    prdt_tgt
);

    bpu_state_e state;
    bpu_state_e state_nxt;
    jalr_src_e  jalr_src;
    logic       dep;
    logic       use_jalr;
    logic       bxx_taken;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] sum;
    logic [PC_W-1:0] tgt;
    logic       vld_c;
    logic       taken_c;
    logic       wait_c;
    logic       ena_c;

    e203_ifu_bpu_depchk #(.RFIDX_W(RFIDX_W)) u_depchk (
        .rs1idx     (dec_jalr_rs1idx),
        .oitf_empty (oitf_empty),
        .ir_valid   (ir_valid),
        .ir_rdwen   (ir_rdwen),
        .ir_rdidx   (ir_rdidx),
        .dep        (dep)
    );

    // JAL wins over JALR if both are flagged; classify the JALR base register
    always_comb begin
        use_jalr = dec_jalr & ~dec_jal;
        if (dec_jalr_rs1idx == '0)
            jalr_src = SRC_X0;
        else if (dec_jalr_rs1idx == RFIDX_W'(RFIDX_X1))
            jalr_src = SRC_X1;
        else
            jalr_src = SRC_XN;
`ifdef E203_BPU_BACKWARD_TAKEN_EN
        bxx_taken = dec_bjp_imm[XLEN-1];
`else
        bxx_taken = 1'b0;
`endif
    end

    // Target adder: base selection, XLEN-wide sum, truncation and JALR bit-0 clear
    always_comb begin
        if (state == RD_XN)
            base = rf2bpu_rs1;
        else if (use_jalr && jalr_src == SRC_X0)
            base = '0;
        else if (use_jalr && jalr_src == SRC_X1)
            base = rf2bpu_x1;
        else
            base = XLEN'(pc);
        sum = base + dec_bjp_imm;
        tgt = PC_W'(sum);
        if (use_jalr)
            tgt[0] = 1'b0;
    end

    // Prediction FSM: same-cycle results, dependency stalls and the xN read slot
    always_comb begin
        state_nxt = state;
        vld_c     = 1'b0;
        taken_c   = 1'b0;
        wait_c    = 1'b0;
        ena_c     = 1'b0;
        case (state)
            IDLE: begin
                if (dec_vld) begin
                    if (dec_jal) begin
                        vld_c   = 1'b1;
                        taken_c = 1'b1;
                    end else if (dec_jalr) begin
                        if (jalr_src == SRC_X0) begin
                            vld_c   = 1'b1;
                            taken_c = 1'b1;
                        end else if (dep) begin
                            wait_c    = 1'b1;
                            state_nxt = DEP_WAIT;
                        end else if (jalr_src == SRC_X1) begin
                            vld_c   = 1'b1;
                            taken_c = 1'b1;
                        end else begin
                            ena_c     = 1'b1;
                            wait_c    = 1'b1;
                            state_nxt = RD_XN;
                        end
                    end else if (dec_bxx) begin
                        vld_c   = 1'b1;
                        taken_c = bxx_taken;
                    end else begin
                        vld_c = 1'b1;
                    end
                end
            end
            DEP_WAIT: begin
                if (!dec_vld) begin
                    state_nxt = IDLE;
                end else if (dep) begin
                    wait_c = 1'b1;
                end else if (jalr_src == SRC_XN) begin
                    ena_c     = 1'b1;
                    wait_c    = 1'b1;
                    state_nxt = RD_XN;
                end else begin
                    vld_c     = 1'b1;
                    taken_c   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RD_XN: begin
                state_nxt = IDLE;
                if (dec_vld) begin
                    vld_c   = 1'b1;
                    taken_c = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are quiet while reset is held so a pending read result never escapes
    always_comb begin
        prdt_vld       = rst_n & vld_c;
        prdt_taken     = rst_n & taken_c;
        bpu_wait       = rst_n & wait_c;
        bpu2rf_rs1_ena = rst_n & ena_c;
        prdt_tgt       = (rst_n && vld_c) ? tgt : '0;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

endmodule

// File: tb/tb_e203_ifu_bpu_prdt.sv
// tb/tb_e203_ifu_bpu_prdt.sv - self-checking bench for e203_ifu_bpu_prdt
module tb_e203_ifu_bpu_prdt;

    logic        clk;
    logic        rst_n;
    logic        dec_vld, dec_jal, dec_jalr, dec_bxx;
    logic [31:0] dec_bjp_imm;
    logic [4:0]  dec_jalr_rs1idx;
    logic [31:0] pc;
    logic        oitf_empty, ir_valid, ir_rdwen;
    logic [4:0]  ir_rdidx;
    logic [31:0] rf2bpu_x1, rf2bpu_rs1;
    logic        bpu2rf_rs1_ena, bpu_wait, prdt_vld, prdt_taken;
    logic [31:0] prdt_tgt;

    int n_checks = 0;
    int n_fail   = 0;

    e203_ifu_bpu_prdt #(.PC_W(32), .XLEN(32), .RFIDX_W(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dec_vld         (dec_vld),
        .dec_jal         (dec_jal),
        .dec_jalr        (dec_jalr),
        .dec_bxx         (dec_bxx),
        .dec_bjp_imm     (dec_bjp_imm),
        .dec_jalr_rs1idx (dec_jalr_rs1idx),
        .pc              (pc),
        .oitf_empty      (oitf_empty),
        .ir_valid        (ir_valid),
        .ir_rdwen        (ir_rdwen),
        .ir_rdidx        (ir_rdidx),
        .rf2bpu_x1       (rf2bpu_x1),
        .rf2bpu_rs1      (rf2bpu_rs1),
        .bpu2rf_rs1_ena  (bpu2rf_rs1_ena),
        .bpu_wait        (bpu_wait),
        .prdt_vld        (prdt_vld),
        .prdt_taken      (prdt_taken),
        .prdt_tgt        (prdt_tgt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // class codes: 0 JAL, 1 BXX, 2 JALR x0, 3 JALR x1, 4 JALR xN, 5 non-jump
    task automatic drive_insn(input int cls, input logic [31:0] p, input logic [31:0] imm,
                              input logic [4:0] idx);
        dec_vld         = 1'b1;
        dec_jal         = (cls == 0);
        dec_bxx         = (cls == 1);
        dec_jalr        = (cls >= 2 && cls <= 4);
        dec_jalr_rs1idx = idx;
        dec_bjp_imm     = imm;
        pc              = p;
    endtask

    task automatic no_dep(input logic [4:0] idx);
        oitf_empty = 1'b1;
        ir_valid   = 1'($urandom_range(0, 1));
        ir_rdwen   = 1'($urandom_range(0, 1));
        ir_rdidx   = idx + 5'd1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        next_cycle();
        drive_insn(0, 32'h1000, 32'h20, 5'd0);
        no_dep(5'd0);
        @(negedge clk);
        n_checks++;
        if ({prdt_vld, prdt_taken, bpu_wait, bpu2rf_rs1_ena} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {prdt_vld, prdt_taken, bpu_wait, bpu2rf_rs1_ena});
        end
        n_checks++;
        if (prdt_tgt !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_tgt: got %h expected 00000000", prdt_tgt);
        end
        next_cycle();
        rst_n   = 1'b1;
        dec_vld = 1'b0;
    endtask

    task automatic test_jal();
        logic [31:0] p [2] = '{32'h0000_1000, 32'hFFFF_FFF8};
        logic [31:0] im[2] = '{32'h0000_0020, 32'h0000_0010};
        logic [31:0] ex[2] = '{32'h0000_1020, 32'h0000_0008};
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            drive_insn(0, p[i], im[i], 5'd3);
            no_dep(5'd3);
            @(negedge clk);
            n_checks++;
            if ({prdt_vld, prdt_taken, bpu_wait, bpu2rf_rs1_ena} !== 4'b1100) begin
                n_fail++;
                $display("FAIL jal_flags[%0d]: got %b expected 1100", i, {prdt_vld, prdt_taken, bpu_wait, bpu2rf_rs1_ena});
            end
            n_checks++;
            if (prdt_tgt !== ex[i]) begin
                n_fail++;
                $display("FAIL jal_tgt[%0d]: got %h expected %h", i, prdt_tgt, ex[i]);
            end
        end
    endtask

    task automatic test_bxx();
        logic exp_taken;
`ifdef E203_BPU_BACKWARD_TAKEN_EN
        exp_taken = 1'b1;
`else
        exp_taken = 1'b0;
`endif
        next_cycle();
        drive_insn(1, 32'h2000, 32'hFFFF_FFF0, 5'd0);
        no_dep(5'd0);
        @(negedge clk);
        n_checks++;
        if ({prdt_vld, prdt_taken, bpu_wait} !== {1'b1, exp_taken, 1'b0}) begin
            n_fail++;
            $display("FAIL bxx_flags: got %b expected %b", {prdt_vld, prdt_taken, bpu_wait}, {1'b1, exp_taken, 1'b0});
        end
        n_checks++;
        if (prdt_tgt !== 32'h1FF0) begin
            n_fail++;
            $display("FAIL bxx_tgt: got %h expected 00001ff0", prdt_tgt);
        end
    endtask

    task automatic test_jalr_x1_dep();
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            drive_insn(3, 32'h500, 32'h4, 5'd1);
            rf2bpu_x1  = 32'h3001;
            oitf_empty = 1'b1;
            ir_valid   = (c < 2);
            ir_rdwen   = 1'b1;
            ir_rdidx   = 5'd1;
            @(negedge clk);
            n_checks++;
            if (c < 2 && {prdt_vld, bpu_wait, bpu2rf_rs1_ena} !== 3'b010) begin
                n_fail++;
                $display("FAIL x1_wait[%0d]: got %b expected 010", c, {prdt_vld, bpu_wait, bpu2rf_rs1_ena});
            end
            if (c == 2 && {prdt_vld, prdt_taken, bpu_wait, bpu2rf_rs1_ena, prdt_tgt} !== {4'b1100, 32'h3004}) begin
                n_fail++;
                $display("FAIL x1_result: got %b tgt %h expected 1100 tgt 00003004",
                         {prdt_vld, prdt_taken, bpu_wait, bpu2rf_rs1_ena}, prdt_tgt);
            end
        end
    endtask

    task automatic test_jalr_xn();
        next_cycle();
        drive_insn(4, 32'h600, 32'h8, 5'd5);
        no_dep(5'd5);
        rf2bpu_rs1 = $urandom;
        @(negedge clk);
        n_checks++;
        if ({prdt_vld, bpu_wait, bpu2rf_rs1_ena} !== 3'b011) begin
            n_fail++;
            $display("FAIL xn_req: got %b expected 011", {prdt_vld, bpu_wait, bpu2rf_rs1_ena});
        end
        next_cycle();
        rf2bpu_rs1 = 32'h4000;
        @(negedge clk);
        n_checks++;
        if ({prdt_vld, prdt_taken, bpu_wait, bpu2rf_rs1_ena, prdt_tgt} !== {4'b1100, 32'h4008}) begin
            n_fail++;
            $display("FAIL xn_result: got %b tgt %h expected 1100 tgt 00004008",
                     {prdt_vld, prdt_taken, bpu_wait, bpu2rf_rs1_ena}, prdt_tgt);
        end
    endtask

    // flush in DEP_WAIT (with the dependency clearing at the same time) and in RD_XN
    task automatic test_flush();
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            drive_insn(4, 32'h700, 32'h10, 5'd7);
            no_dep(5'd7);
            oitf_empty = (k == 1);
            @(negedge clk);
            n_checks++;
            if ({prdt_vld, bpu_wait, bpu2rf_rs1_ena} !== {2'b01, k[0]}) begin
                n_fail++;
                $display("FAIL flush_first[%0d]: got %b expected %b", k, {prdt_vld, bpu_wait, bpu2rf_rs1_ena}, {2'b01, k[0]});
            end
            next_cycle();
            dec_vld    = 1'b0;
            oitf_empty = 1'b1;
            @(negedge clk);
            n_checks++;
            if ({prdt_vld, bpu2rf_rs1_ena} !== 2'b00) begin
                n_fail++;
                $display("FAIL flush_abort[%0d]: got %b expected 00", k, {prdt_vld, bpu2rf_rs1_ena});
            end
            next_cycle();
            drive_insn(0, 32'h40, 32'h4, 5'd0);
            @(negedge clk);
            n_checks++;
            if ({prdt_vld, bpu_wait, prdt_tgt} !== {2'b10, 32'h44}) begin
                n_fail++;
                $display("FAIL flush_idle[%0d]: got %b tgt %h expected 10 tgt 00000044", k, {prdt_vld, bpu_wait}, prdt_tgt);
            end
        end
    endtask

    task automatic test_reset_mid();
        next_cycle();
        drive_insn(4, 32'h800, 32'h4, 5'd9);
        no_dep(5'd9);
        for (int c = 0; c < 4; c++) begin
            if (c > 0)
                next_cycle();
            rst_n      = !(c == 1 || c == 2);
            rf2bpu_rs1 = 32'h9000;
            @(negedge clk);
            n_checks++;
            if (c == 1 || c == 2) begin
                if ({prdt_vld, prdt_taken, bpu_wait, bpu2rf_rs1_ena, prdt_tgt} !== 36'h0) begin
                    n_fail++;
                    $display("FAIL rstmid_zero[%0d]: got %b tgt %h expected all zero", c,
                             {prdt_vld, prdt_taken, bpu_wait, bpu2rf_rs1_ena}, prdt_tgt);
                end
            end else if ({prdt_vld, bpu_wait, bpu2rf_rs1_ena} !== 3'b011) begin
                n_fail++;
                $display("FAIL rstmid_req[%0d]: got %b expected 011", c, {prdt_vld, bpu_wait, bpu2rf_rs1_ena});
            end
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({prdt_vld, prdt_tgt} !== {1'b1, 32'h9004}) begin
            n_fail++;
            $display("FAIL rstmid_result: got %b tgt %h expected 1 tgt 00009004", prdt_vld, prdt_tgt);
        end
    endtask

    // random instruction stream against a per-instruction timeline model
    task automatic test_back_to_back();
        for (int n = 0; n < 80; n++) begin
            int          cls, d;
            logic [31:0] p, imm, x1v, rsv, base, exp_tgt;
            logic [4:0]  idx;
            logic        exp_taken;
            cls = $urandom_range(0, 5);
            p   = $urandom;
            imm = $urandom;
            x1v = $urandom;
            rsv = $urandom;
            idx = (cls == 2) ? 5'd0 : (cls == 3) ? 5'd1 : (cls == 4) ? 5'($urandom_range(2, 31))
                                                                     : 5'($urandom_range(0, 31));
            d   = (cls == 3 || cls == 4) ? $urandom_range(0, 2) : 0;
            base = (cls == 2) ? 32'h0 : (cls == 3) ? x1v : (cls == 4) ? rsv : p;
            exp_tgt = base + imm;
            if (cls >= 2 && cls <= 4)
                exp_tgt[0] = 1'b0;
`ifdef E203_BPU_BACKWARD_TAKEN_EN
            exp_taken = (cls == 1) ? imm[31] : (cls != 5);
`else
            exp_taken = (cls != 1 && cls != 5);
`endif
            for (int c = 0; c < d + ((cls == 4) ? 2 : 1); c++) begin
                next_cycle();
                drive_insn(cls, p, imm, idx);
                rf2bpu_x1  = x1v;
                rf2bpu_rs1 = $urandom;
                if (c < d) begin
                    if ($urandom_range(0, 1) == 0) begin
                        oitf_empty = 1'b0;
                    end else begin
                        oitf_empty = 1'b1;
                        ir_valid   = 1'b1;
                        ir_rdwen   = 1'b1;
                        ir_rdidx   = idx;
                    end
                end else if (cls < 3 || cls == 5) begin
                    oitf_empty = 1'($urandom_range(0, 1));
                    ir_valid   = 1'($urandom_range(0, 1));
                    ir_rdwen   = 1'($urandom_range(0, 1));
                    ir_rdidx   = 5'($urandom_range(0, 31));
                end else begin
                    no_dep(idx);
                end
                if (cls == 4 && c == d + 1)
                    rf2bpu_rs1 = rsv;
                @(negedge clk);
                n_checks++;
                if (c < d) begin
                    if ({prdt_vld, bpu_wait, bpu2rf_rs1_ena} !== 3'b010) begin
                        n_fail++;
                        $display("FAIL rnd_dep[%0d.%0d] cls %0d: got %b expected 010", n, c, cls, {prdt_vld, bpu_wait, bpu2rf_rs1_ena});
                    end
                end else if (cls == 4 && c == d) begin
                    if ({prdt_vld, bpu_wait, bpu2rf_rs1_ena} !== 3'b011) begin
                        n_fail++;
                        $display("FAIL rnd_req[%0d] cls %0d: got %b expected 011", n, cls, {prdt_vld, bpu_wait, bpu2rf_rs1_ena});
                    end
                end else if ({prdt_vld, prdt_taken, bpu_wait, bpu2rf_rs1_ena} !== {1'b1, exp_taken, 2'b00}
                             || (cls != 5 && prdt_tgt !== exp_tgt)) begin
                    n_fail++;
                    $display("FAIL rnd_result[%0d] cls %0d: got %b tgt %h expected %b tgt %h", n, cls,
                             {prdt_vld, prdt_taken, bpu_wait, bpu2rf_rs1_ena}, prdt_tgt,
                             {1'b1, exp_taken, 2'b00}, exp_tgt);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        dec_vld = 1'b0; dec_jal = 1'b0; dec_jalr = 1'b0; dec_bxx = 1'b0;
        dec_bjp_imm = '0; dec_jalr_rs1idx = '0; pc = '0;
        oitf_empty = 1'b1; ir_valid = 1'b0; ir_rdwen = 1'b0; ir_rdidx = '0;
        rf2bpu_x1 = '0; rf2bpu_rs1 = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_jal();
        test_bxx();
        test_jalr_x1_dep();
        test_jalr_xn();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
